// File: rtl/frame_sequencer_pkg.sv
// Shared constants for the frame sequencer: screen/box geometry and the
// FSM state encodings.
package frame_sequencer_pkg;

   localparam int GRID_W    = 240;
   localparam int GRID_H    = 180;
   localparam int BOX_SIZE  = 60;
   localparam int NUM_BOXES = 12;

   // Terminal values of the scan counters
   localparam logic [7:0] GRID_X_LAST = 8'(GRID_W - 1);
   localparam logic [7:0] GRID_Y_LAST = 8'(GRID_H - 1);
   localparam logic [7:0] BOX_X_LAST  = 8'(BOX_SIZE - 1);
   localparam logic [6:0] BOX_Y_LAST  = 7'(BOX_SIZE - 1);
   localparam logic [3:0] BOX_LAST    = 4'(NUM_BOXES);

   // Sequencer states
   typedef logic [3:0] state_t;
   localparam state_t S_IDLE  = 4'd0;
   localparam state_t S_CLEAR = 4'd1;
   localparam state_t S_WAIT  = 4'd2;
   localparam state_t S_SCORE = 4'd3;
   localparam state_t S_ADD   = 4'd4;
   localparam state_t S_SHIFT = 4'd5;
   localparam state_t S_DRAW  = 4'd6;
   localparam state_t S_FLUSH = 4'd7;
   localparam state_t S_DONE  = 4'd8;

endpackage

// File: rtl/frame_sequencer_if.sv
// Bus between the frame sequencer (master) and the song/VGA datapath (slave):
// start/pause requests in, scan counters, addresses and datapath strobes out.
interface frame_sequencer_if;

   logic        start;
   logic        pause;
   logic [15:0] gridCounter;
   logic [15:0] memAddressGridCounter;
   logic [3:0]  boxCounter;
   logic [14:0] pixelCount;
   logic [14:0] memAddressPixelCount;
   logic        loadDefault;
   logic        writeDefault;
   logic        loadX;
   logic        loadY;
   logic        writeToScreen;
   logic        shiftSong;
   logic        changeScore;
   logic        addScore;
   logic        songDone;
   logic        plot;
   logic        busy;

   modport master (
      input  start, pause,
      output gridCounter, memAddressGridCounter, boxCounter, pixelCount,
             memAddressPixelCount, loadDefault, writeDefault, loadX, loadY,
             writeToScreen, shiftSong, changeScore, addScore, songDone,
             plot, busy
   );

   modport slave (
      output start, pause,
      input  gridCounter, memAddressGridCounter, boxCounter, pixelCount,
             memAddressPixelCount, loadDefault, writeDefault, loadX, loadY,
             writeToScreen, shiftSong, changeScore, addScore, songDone,
             plot, busy
   );

endinterface

// File: rtl/frame_tick_timer.sv
// Song-step timer: counts 0..FRAME_TICKS-1 while run is high and remembers
// at most one tick that arrived while the sequencer was not waiting.
// Optional feature: define FRAME_PAUSE_EN to let pause freeze the timer and
// hold the sequencer in WAIT; otherwise pause is ignored.
module frame_tick_timer #(
   parameter int FRAME_TICKS = 12500000
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic inWait,
   input  logic pause,
   output logic tickReady
);

   localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CW-1:0] COUNT_LAST = CW'(FRAME_TICKS - 1);

   logic [CW-1:0] count;
   logic          pending;
   logic          pauseGate;
   logic          advance;
   logic          tick;

`ifdef FRAME_PAUSE_EN
   assign pauseGate = pause;
`else
   logic unusedPause;
   assign unusedPause = pause;
   assign pauseGate   = 1'b0;
`endif

   assign advance   = run & ~pauseGate;
   assign tick      = advance & (count == COUNT_LAST);
   assign tickReady = (tick | pending) & ~pauseGate;

   // Free-running step counter, held at zero while the song is not playing
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (!run)
         count <= '0;
      else if (advance)
         count <= tick ? '0 : count + CW'(1);
   end

   // One-deep tick memory: consumed by an unpaused WAIT, extra ticks dropped
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pending <= 1'b0;
      else if (!run)
         pending <= 1'b0;
      else if (inWait && !pauseGate)
         pending <= 1'b0;
      else if (tick)
         pending <= 1'b1;
   end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: clears the screen to the default image, then once per
// song step updates the score, shifts the song and redraws the 12 boxes.
// Every pixel-issuing phase is followed by FLUSH, which keeps the phase's
// strobes up for PLOT_LAT cycles so the delayed plot pulses drain.
// PLOT_LAT must be at least 1. Optional feature: FRAME_PAUSE_EN (see
// frame_tick_timer).
module frame_sequencer
   import frame_sequencer_pkg::*;
#(
   parameter int FRAME_TICKS = 12500000,
   parameter int SONG_STEPS  = 112,
   parameter int PLOT_LAT    = 3
) (
   input logic               clock,
   input logic               reset,
   frame_sequencer_if.master bus
);

   localparam int STEP_W = $clog2(SONG_STEPS + 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SONG_STEPS);
   localparam int LAT_W = $clog2(PLOT_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PLOT_LAT - 1);

   state_t              state;
   state_t              stateNext;
   logic [7:0]          gridX;
   logic [7:0]          gridY;
   logic [15:0]         gridAddr;
   logic [3:0]          box;
   logic [7:0]          pixX;
   logic [6:0]          pixY;
   logic [14:0]         pixAddr;
   logic [STEP_W-1:0]   stepCount;
   logic [LAT_W-1:0]    flushCount;
   logic                fromDraw;
   logic [PLOT_LAT-1:0] plotPipe;
   logic                gridLast;
   logic                drawLast;
   logic                flushLast;
   logic                timerRun;
   logic                tickReady;

   assign gridLast  = (gridX == GRID_X_LAST) && (gridY == GRID_Y_LAST);
   assign drawLast  = (box == BOX_LAST) && (pixX == BOX_X_LAST) && (pixY == BOX_Y_LAST);
   assign flushLast = (flushCount == LAT_LAST);
   assign timerRun  = (state != S_IDLE) && (state != S_CLEAR) && (state != S_DONE);

   frame_tick_timer #(
      .FRAME_TICKS(FRAME_TICKS)
   ) tickTimer (
      .clock    (clock),
      .reset    (reset),
      .run      (timerRun),
      .inWait   (state == S_WAIT),
      .pause    (bus.pause),
      .tickReady(tickReady)
   );

   // Next-state decode
   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE:  if (bus.start) stateNext = S_CLEAR;
         S_CLEAR: if (gridLast) stateNext = S_FLUSH;
         S_WAIT:  if (tickReady) stateNext = S_SCORE;
         S_SCORE: stateNext = S_ADD;
         S_ADD:   stateNext = S_SHIFT;
         S_SHIFT: stateNext = S_DRAW;
         S_DRAW:  if (drawLast) stateNext = S_FLUSH;
         S_FLUSH: if (flushLast)
                     stateNext = (fromDraw && stepCount == STEP_LAST) ? S_DONE : S_WAIT;
         S_DONE:  stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= stateNext;
   end

   // Default-image grid scan: advances in CLEAR, frozen in FLUSH, zero elsewhere
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gridX    <= '0;
         gridY    <= '0;
         gridAddr <= '0;
      end else if (state == S_CLEAR) begin
         if (!gridLast) begin
            gridAddr <= gridAddr + 16'd1;
            if (gridX == GRID_X_LAST) begin
               gridX <= '0;
               gridY <= gridY + 8'd1;
            end else begin
               gridX <= gridX + 8'd1;
            end
         end
      end else if (state != S_FLUSH) begin
         gridX    <= '0;
         gridY    <= '0;
         gridAddr <= '0;
      end
   end

   // Box/pixel scan: primed in SHIFT, advances in DRAW, frozen in FLUSH
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         box     <= '0;
         pixX    <= '0;
         pixY    <= '0;
         pixAddr <= '0;
      end else if (state == S_SHIFT) begin
         box     <= 4'd1;
         pixX    <= '0;
         pixY    <= '0;
         pixAddr <= '0;
      end else if (state == S_DRAW) begin
         if (!drawLast) begin
            if (pixX == BOX_X_LAST) begin
               pixX <= '0;
               if (pixY == BOX_Y_LAST) begin
                  pixY    <= '0;
                  pixAddr <= '0;
                  box     <= box + 4'd1;
               end else begin
                  pixY    <= pixY + 7'd1;
                  pixAddr <= pixAddr + 15'd1;
               end
            end else begin
               pixX    <= pixX + 8'd1;
               pixAddr <= pixAddr + 15'd1;
            end
         end
      end else if (state != S_FLUSH) begin
         box     <= '0;
         pixX    <= '0;
         pixY    <= '0;
         pixAddr <= '0;
      end
   end

   // Song step count, FLUSH length and which phase FLUSH is draining
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stepCount  <= '0;
         flushCount <= '0;
         fromDraw   <= 1'b0;
      end else begin
         if (state == S_SHIFT)
            stepCount <= stepCount + STEP_W'(1);
         else if (state == S_DONE)
            stepCount <= '0;
         if (state == S_FLUSH)
            flushCount <= flushCount + LAT_W'(1);
         else
            flushCount <= '0;
         if (state == S_CLEAR)
            fromDraw <= 1'b0;
         else if (state == S_DRAW)
            fromDraw <= 1'b1;
      end
   end

   // Plot delay line fed only by cycles that issue a new pixel (CLEAR/DRAW)
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         plotPipe <= '0;
      else
         plotPipe <= (plotPipe << 1) | PLOT_LAT'((state == S_CLEAR) || (state == S_DRAW));
   end

   // Datapath strobes decoded from the state
   always_comb begin
      bus.loadDefault   = 1'b0;
      bus.writeDefault  = 1'b0;
      bus.loadX         = 1'b0;
      bus.loadY         = 1'b0;
      bus.writeToScreen = 1'b0;
      bus.shiftSong     = 1'b0;
      bus.changeScore   = 1'b0;
      bus.addScore      = 1'b0;
      bus.songDone      = 1'b0;
      case (state)
         S_CLEAR: begin
            bus.loadDefault  = 1'b1;
            bus.writeDefault = 1'b1;
         end
         S_DRAW: begin
            bus.loadX         = 1'b1;
            bus.loadY         = 1'b1;
            bus.writeToScreen = 1'b1;
         end
         S_FLUSH: begin
            bus.loadDefault   = ~fromDraw;
            bus.writeDefault  = ~fromDraw;
            bus.loadX         = fromDraw;
            bus.loadY         = fromDraw;
            bus.writeToScreen = fromDraw;
         end
         S_SCORE: bus.changeScore = 1'b1;
         S_ADD:   bus.addScore    = 1'b1;
         S_SHIFT: bus.shiftSong   = 1'b1;
         S_DONE: begin
            bus.songDone     = 1'b1;
            bus.writeDefault = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.gridCounter           = {gridX, gridY};
   assign bus.memAddressGridCounter = gridAddr;
   assign bus.boxCounter            = box;
   assign bus.pixelCount            = {pixX, pixY};
   assign bus.memAddressPixelCount  = pixAddr;
   assign bus.plot                  = plotPipe[PLOT_LAT-1];
   assign bus.busy                  = (state != S_IDLE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer. Four instances run side by side:
// A main sequence (clear, first step, pending-tick service), D song end with
// SONG_STEPS=1, E reset in the middle of DRAW, P pause held high.
module tb_frame_sequencer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic resetE = 1'b1;

   int total = 0;
   int bad = 0;
   int pShifts = 0;
   int ePlots = 0;
   bit eArmed = 1'b0;

   always #5 clock = ~clock;

   frame_sequencer_if ifA ();
   frame_sequencer_if ifD ();
   frame_sequencer_if ifE ();
   frame_sequencer_if ifP ();

   frame_sequencer #(.FRAME_TICKS(64), .SONG_STEPS(112), .PLOT_LAT(3)) dutA (
      .clock(clock), .reset(reset), .bus(ifA));
   frame_sequencer #(.FRAME_TICKS(64), .SONG_STEPS(1), .PLOT_LAT(3)) dutD (
      .clock(clock), .reset(reset), .bus(ifD));
   frame_sequencer #(.FRAME_TICKS(64), .SONG_STEPS(112), .PLOT_LAT(3)) dutE (
      .clock(clock), .reset(resetE), .bus(ifE));
   frame_sequencer #(.FRAME_TICKS(64), .SONG_STEPS(112), .PLOT_LAT(3)) dutP (
      .clock(clock), .reset(reset), .bus(ifP));

   task automatic checkValue(input string tag, input logic [31:0] seen, input logic [31:0] want);
      total++;
      if (seen !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, seen, want);
      end
   endtask

   always @(negedge clock) begin
      if (ifP.shiftSong) pShifts++;
      if (eArmed && ifE.plot) ePlots++;
   end

   // Main instance: clear scan, first song step, draw scan, pending tick
   task automatic runMain();
      int n;
      int errs;
      int plots;
      logic [15:0] lastGrid;
      logic [15:0] lastAddr;
      logic [3:0]  lastBox;
      logic [14:0] lastPix;
      n = 0;
      while (!ifA.writeDefault && n < 20) begin @(negedge clock); n++; end
      checkValue("clear_start", ifA.writeDefault, 1);
      checkValue("clear_first_grid", ifA.gridCounter, 16'h0000);
      errs = 0; plots = 0; lastGrid = '0; lastAddr = '0;
      for (int i = 0; i < 43200; i++) begin
         if (ifA.gridCounter !== {8'(i % 240), 8'(i / 240)} ||
             ifA.memAddressGridCounter !== 16'(i) || !ifA.loadDefault ||
             !ifA.writeDefault || ifA.writeToScreen || ifA.plot !== (i >= 3))
            errs++;
         if (ifA.plot) plots++;
         lastGrid = ifA.gridCounter;
         lastAddr = ifA.memAddressGridCounter;
         @(negedge clock);
      end
      for (int i = 0; i < 3; i++) begin
         if (!ifA.writeDefault || ifA.gridCounter !== 16'hEFB3 || !ifA.plot) errs++;
         if (ifA.plot) plots++;
         @(negedge clock);
      end
      checkValue("clear_scan_errors", errs, 0);
      checkValue("clear_last_grid", lastGrid, 16'hEFB3);
      checkValue("clear_last_addr", lastAddr, 43199);
      checkValue("clear_plots", plots, 43200);
      checkValue("wait_quiet", {ifA.writeDefault, ifA.plot, ifA.busy, ifA.boxCounter}, 7'b0010000);
      n = 0;
      while (!ifA.changeScore && n < 1000) begin @(negedge clock); n++; end
      checkValue("wait_cycles", n, 61);
      checkValue("seq_score", {ifA.changeScore, ifA.addScore, ifA.shiftSong}, 3'b100);
      @(negedge clock);
      checkValue("seq_add", {ifA.changeScore, ifA.addScore, ifA.shiftSong}, 3'b010);
      @(negedge clock);
      checkValue("seq_shift", {ifA.changeScore, ifA.addScore, ifA.shiftSong}, 3'b001);
      @(negedge clock);
      checkValue("draw_first_box", ifA.boxCounter, 1);
      checkValue("draw_first_pixel", ifA.pixelCount, 0);
      errs = 0; plots = 0; lastBox = '0; lastPix = '0;
      for (int i = 0; i < 43200; i++) begin
         if (ifA.boxCounter !== 4'(i / 3600 + 1) ||
             ifA.pixelCount !== {8'((i % 3600) % 60), 7'((i % 3600) / 60)} ||
             ifA.memAddressPixelCount !== 15'(i % 3600) || !ifA.loadX || !ifA.loadY ||
             !ifA.writeToScreen || ifA.writeDefault || ifA.shiftSong ||
             ifA.plot !== (i >= 3))
            errs++;
         if (i == 3) checkValue("first_plot_lat", ifA.plot, 1);
         if (ifA.plot) plots++;
         lastBox = ifA.boxCounter;
         lastPix = ifA.pixelCount;
         @(negedge clock);
      end
      for (int i = 0; i < 3; i++) begin
         if (!ifA.writeToScreen || ifA.boxCounter !== 4'd12 ||
             ifA.pixelCount !== 15'h1DBB || !ifA.plot) errs++;
         if (ifA.plot) plots++;
         @(negedge clock);
      end
      checkValue("draw_scan_errors", errs, 0);
      checkValue("draw_last_box", lastBox, 12);
      checkValue("draw_last_pixel", lastPix, 15'h1DBB);
      checkValue("draw_plots", plots, 43200);
      checkValue("pend_wait_quiet", {ifA.writeToScreen, ifA.plot, ifA.changeScore, ifA.busy}, 4'b0001);
      n = 0;
      while (!ifA.changeScore && n < 10) begin @(negedge clock); n++; end
      checkValue("pend_wait_cycles", n, 1);
      @(negedge clock);
      checkValue("pend_add", {ifA.changeScore, ifA.addScore, ifA.shiftSong}, 3'b010);
      @(negedge clock);
      checkValue("pend_shift", {ifA.changeScore, ifA.addScore, ifA.shiftSong}, 3'b001);
      @(negedge clock);
      checkValue("second_draw_box", ifA.boxCounter, 1);
   endtask

   // SONG_STEPS=1: song ends right after the first draw's flush
   task automatic runDone();
      int n;
      n = 0;
      while (!ifD.writeToScreen && n < 50000) begin @(negedge clock); n++; end
      checkValue("done_draw_seen", ifD.writeToScreen, 1);
      n = 0;
      while (!ifD.songDone && n < 50000) begin @(negedge clock); n++; end
      checkValue("done_offset", n, 43203);
      checkValue("done_write_default", {ifD.songDone, ifD.writeDefault, ifD.busy}, 3'b111);
      @(negedge clock);
      checkValue("done_single_pulse", ifD.songDone, 0);
      checkValue("done_busy_fall", ifD.busy, 0);
   endtask

   // Reset asserted at DRAW pixel 1000 of box 1
   task automatic runReset();
      int n;
      n = 0;
      while (!(ifE.writeToScreen && ifE.boxCounter == 4'd1 && ifE.memAddressPixelCount == 15'd1000) &&
             n < 50000) begin
         @(negedge clock); n++;
      end
      checkValue("rst_reached_pixel", ifE.memAddressPixelCount, 1000);
      checkValue("rst_plot_before", ifE.plot, 1);
      resetE = 1'b1;
      #1;
      checkValue("rst_strobes_zero",
                 {ifE.busy, ifE.writeToScreen, ifE.loadX, ifE.loadY, ifE.plot}, 5'b0);
      checkValue("rst_counters_zero",
                 {ifE.boxCounter, ifE.pixelCount, ifE.memAddressPixelCount}, 34'b0);
      @(negedge clock);
      resetE = 1'b0;
      eArmed = 1'b1;
   endtask

   initial begin
      ifA.start = 1'b0; ifD.start = 1'b0; ifE.start = 1'b0; ifP.start = 1'b0;
      ifA.pause = 1'b0; ifD.pause = 1'b0; ifE.pause = 1'b0; ifP.pause = 1'b1;
      repeat (3) @(negedge clock);
      checkValue("reset_strobes",
                 {ifA.loadDefault, ifA.writeDefault, ifA.loadX, ifA.loadY, ifA.writeToScreen,
                  ifA.shiftSong, ifA.changeScore, ifA.addScore, ifA.songDone, ifA.plot, ifA.busy},
                 11'b0);
      checkValue("reset_grid", ifA.gridCounter, 0);
      checkValue("reset_box_pixel", {ifA.boxCounter, ifA.pixelCount}, 0);
      reset = 1'b0;
      resetE = 1'b0;
      @(negedge clock);
      checkValue("idle_no_start", ifA.busy, 0);
      ifA.start = 1'b1; ifD.start = 1'b1; ifE.start = 1'b1; ifP.start = 1'b1;
      @(negedge clock);
      ifA.start = 1'b0; ifD.start = 1'b0; ifE.start = 1'b0; ifP.start = 1'b0;
      fork
         runMain();
         runDone();
         runReset();
      join
      @(negedge clock);
      checkValue("rst_no_plot_after", ePlots, 0);
      checkValue("rst_stays_idle", ifE.busy, 0);
`ifdef FRAME_PAUSE_EN
      checkValue("pause_holds_shift", pShifts, 0);
      checkValue("pause_busy", ifP.busy, 1);
`else
      checkValue("pause_ignored_shifts", pShifts, 2);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      repeat (100000) @(posedge clock);
      $display("FAIL watchdog: cycle limit 100000 reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
